// File: rtl/prbs_pkg.sv
`timescale 1ns/1ps
// Shared PRBS7 constants, predictor helper and checker state encoding.
// Pure declarations, no latency.
// No flow control.
package prbs_pkg;

   // PRBS7: x^7 + x^6 + 1, LFSR shifts left, feedback enters at bit 0
   localparam int PRBS_ORDER = 7;
   localparam int PRBS_TAP_A = 6;
   localparam int PRBS_TAP_B = 5;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } chk_state_e;

   // Next sequence bit implied by the current LFSR contents
   function automatic logic prbs7_predict(input logic [PRBS_ORDER-1:0] s);
      return s[PRBS_TAP_A] ^ s[PRBS_TAP_B];
   endfunction

endpackage

// File: rtl/prbs7_lfsr.sv
`timescale 1ns/1ps
// PRBS7 shift register: loads serial din (seeding) or free-runs on its own feedback.
// pred is combinational from the current state; state updates one edge after en.
// No backpressure: en simply qualifies the shift.
module prbs7_lfsr
   import prbs_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  en,
   input  logic                  load,
   input  logic                  din,
   output logic                  pred,
   output logic [PRBS_ORDER-1:0] lfsr_nxt
);

   logic [PRBS_ORDER-1:0] lfsr_q;
   logic [PRBS_ORDER-1:0] lfsr_d;

   // Select the incoming bit (load) or the predicted bit (free-run) as the new LSB
   always_comb begin
      pred     = prbs7_predict(lfsr_q);
      lfsr_nxt = {lfsr_q[PRBS_ORDER-2:0], (load ? din : pred)};
      lfsr_d   = en ? lfsr_nxt : lfsr_q;
   end

   // State register, cleared to all-zero on reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_q <= '0;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

endmodule

// File: rtl/prbs_shift_checker.sv
`timescale 1ns/1ps
// Self-synchronising PRBS7 checker for a delay-line serial output; counts bit errors.
// Lock/err_pulse/err_count update on the edge that samples the qualified bit (1-cycle latency).
// No backpressure: enable=0 freezes all state, clear_cnt acts regardless of enable.
module prbs_shift_checker
   import prbs_pkg::*;
#(
   parameter int LOCK_COUNT    = 16,
   parameter int UNLOCK_ERRORS = 4,
   parameter int UNLOCK_WINDOW = 64,
   parameter int ERR_CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic                 din,
   input  logic                 clear_cnt,
   output logic                 locked,
   output logic                 err_pulse,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int FILL_W  = $clog2(PRBS_ORDER);
   localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam int WIN_W   = (UNLOCK_WINDOW > 1) ? $clog2(UNLOCK_WINDOW) : 1;
   localparam int WERR_W  = $clog2(UNLOCK_ERRORS + 1);

   chk_state_e            state_q, state_d;
   logic [FILL_W-1:0]     fill_q, fill_d;
   logic [MATCH_W-1:0]    match_q, match_d;
   logic [WIN_W-1:0]      win_cnt_q, win_cnt_d;
   logic [WERR_W-1:0]     win_err_q, win_err_d;
   logic [WERR_W-1:0]     win_err_inc;
   logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
   logic                  locked_q, locked_d;
   logic                  err_pulse_q, err_pulse_d;

   logic                  pred;
   logic [PRBS_ORDER-1:0] lfsr_nxt;
   logic                  lfsr_load;
   logic                  mismatch;

   prbs7_lfsr u_lfsr (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (enable),
      .load     (lfsr_load),
      .din      (din),
      .pred     (pred),
      .lfsr_nxt (lfsr_nxt)
   );

   // Next-state and counter logic; only qualified bits advance anything
   always_comb begin
      state_d     = state_q;
      fill_d      = fill_q;
      match_d     = match_q;
      win_cnt_d   = win_cnt_q;
      win_err_d   = win_err_q;
      err_count_d = err_count_q;
      locked_d    = locked_q;
      err_pulse_d = 1'b0;
      lfsr_load   = (state_q == SEARCH);
      mismatch    = din ^ pred;
      win_err_inc = win_err_q + WERR_W'(mismatch);

      if (enable) begin
         case (state_q)
            SEARCH: begin
               // Seed the LFSR straight from the stream; an all-zero seed would lock up
               if (fill_q == FILL_W'(PRBS_ORDER - 1)) begin
                  fill_d = '0;
                  if (lfsr_nxt != '0) begin
                     state_d = VERIFY;
                     match_d = '0;
                  end
               end else begin
                  fill_d = fill_q + FILL_W'(1);
               end
            end

            VERIFY: begin
               if (mismatch) begin
                  state_d = SEARCH;
                  fill_d  = '0;
               end else begin
                  match_d = match_q + MATCH_W'(1);
                  if (match_q + MATCH_W'(1) == MATCH_W'(LOCK_COUNT)) begin
                     state_d  = LOCKED;
                     locked_d = 1'b1;
                  end
               end
            end

            LOCKED: begin
               if (mismatch) begin
                  err_pulse_d = 1'b1;
                  if (err_count_q != '1) begin
                     err_count_d = err_count_q + ERR_CNT_W'(1);
                  end
               end
               // Too many errors in this window: drop lock and resynchronise
               if (mismatch && (win_err_inc == WERR_W'(UNLOCK_ERRORS))) begin
                  state_d   = SEARCH;
                  locked_d  = 1'b0;
                  fill_d    = '0;
                  win_cnt_d = '0;
                  win_err_d = '0;
               end else if (win_cnt_q == WIN_W'(UNLOCK_WINDOW - 1)) begin
                  win_cnt_d = '0;
                  win_err_d = '0;
               end else begin
                  win_cnt_d = win_cnt_q + WIN_W'(1);
                  win_err_d = win_err_inc;
               end
            end

            default: begin
               state_d  = SEARCH;
               fill_d   = '0;
               locked_d = 1'b0;
            end
         endcase
      end

      // Clear wins over a coincident error increment; the pulse still reports it
      if (clear_cnt) begin
         err_count_d = '0;
         win_err_d   = '0;
      end
   end

   // State and counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= SEARCH;
         fill_q      <= '0;
         match_q     <= '0;
         win_cnt_q   <= '0;
         win_err_q   <= '0;
         err_count_q <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_q      <= fill_d;
         match_q     <= match_d;
         win_cnt_q   <= win_cnt_d;
         win_err_q   <= win_err_d;
         err_count_q <= err_count_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs_shift_checker.sv
`timescale 1ns/1ps
// Directed bench for prbs_shift_checker: default instance plus a 4-bit-counter instance.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
// The stream passes through a 32-deep delay-line model before reaching the checkers.
module tb_prbs_shift_checker;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        din;
   logic        din2;
   logic        clear_cnt;
   logic        locked, err_pulse;
   logic [15:0] err_count;
   logic        locked2, err_pulse2;
   logic [3:0]  err_count2;

   int n_vec = 0;
   int n_bad = 0;

   logic [6:0]  gen;
   logic [31:0] dly;

   always #5 clk = ~clk;

   prbs_shift_checker dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .din       (din),
      .clear_cnt (clear_cnt),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count)
   );

   prbs_shift_checker #(
      .LOCK_COUNT    (16),
      .UNLOCK_ERRORS (32),
      .UNLOCK_WINDOW (64),
      .ERR_CNT_W     (4)
   ) dut2 (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .din       (din2),
      .clear_cnt (clear_cnt),
      .locked    (locked2),
      .err_pulse (err_pulse2),
      .err_count (err_count2)
   );

   typedef struct packed {
      logic        en;
      logic        inv;
      logic        clr;
      logic        exp_locked;
      logic        exp_pulse;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t tbl [12];

   function automatic vec_t mk(input logic en, input logic inv, input logic clr,
                               input logic l, input logic p, input logic [15:0] c);
      vec_t v;
      v.en = en; v.inv = inv; v.clr = clr;
      v.exp_locked = l; v.exp_pulse = p; v.exp_cnt = c;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Generator model: emit next PRBS7 bit and push it into the delay line
   task automatic gen_advance();
      logic b;
      b   = gen[6] ^ gen[5];
      gen = {gen[5:0], b};
      dly = {dly[30:0], b};
   endtask

   // One clock of delay-line output to both checkers, with per-instance bit inversion
   task automatic step(input logic en, input logic inv, input logic inv2, input logic clr);
      enable    = en;
      clear_cnt = clr;
      if (en) begin
         din  = dly[31] ^ inv;
         din2 = dly[31] ^ inv2;
      end else begin
         din  = 1'($urandom_range(0, 1));
         din2 = din;
      end
      @(posedge clk);
      #1;
      if (en) gen_advance();
   endtask

   task automatic raw_step(input logic d);
      enable    = 1'b1;
      clear_cnt = 1'b0;
      din       = d;
      din2      = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      enable    = 1'b0;
      clear_cnt = 1'b0;
      din       = 1'b0;
      din2      = 1'b0;
      reset_n   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      gen = 7'h7F;
      dly = '0;
      for (int i = 0; i < 32; i++) gen_advance();
   endtask

   // First PRBS bit reaches the checker on step 1; lock is due on step 23
   task automatic lock_up(input string tag);
      for (int i = 0; i < 22; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      chk({tag, "_locked_at_22"}, 32'(locked), 32'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk({tag, "_locked_at_23"}, 32'(locked), 32'd1);
      chk({tag, "_locked2_at_23"}, 32'(locked2), 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
      $fatal(1, "watchdog");
   end

   initial begin
      int viol;
      int ever_locked;

      // row: en inv clr | locked pulse count
      tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
      tbl[1]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1);  // single error
      tbl[2]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);  // pulse lasts one cycle
      tbl[3]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);  // gated cycle
      tbl[4]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);  // clear
      tbl[5]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0);  // clear beats error
      tbl[6]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1);  // window err 1
      tbl[7]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd2);  // window err 2
      tbl[8]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
      tbl[9]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd3);  // window err 3
      tbl[10] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd4);  // 4th: lock lost
      tbl[11] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4);

      // Reset held with a live, toggling input
      reset_n = 1'b0; enable = 1'b1; clear_cnt = 1'b0; din = 1'b0; din2 = 1'b0;
      viol = 0;
      for (int i = 0; i < 10; i++) begin
         #10;
         din  = ~din;
         din2 = din;
         if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 16'd0) viol++;
      end
      chk("reset_hold_violations", 32'(viol), 32'd0);
      chk("reset_err_count", 32'(err_count), 32'd0);

      // Clean lock then a long clean run
      do_reset();
      lock_up("clean");
      viol = 0;
      for (int i = 0; i < 977; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         if (locked !== 1'b1 || err_pulse !== 1'b0) viol++;
      end
      chk("clean_run_violations", 32'(viol), 32'd0);
      chk("clean_err_count", 32'(err_count), 32'd0);

      // Error-pattern table on a fresh lock
      do_reset();
      lock_up("table");
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].en, tbl[i].inv, 1'b0, tbl[i].clr);
         chk($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].exp_locked));
         chk($sformatf("tbl%0d_pulse", i), 32'(err_pulse), 32'(tbl[i].exp_pulse));
         chk($sformatf("tbl%0d_count", i), 32'(err_count), 32'(tbl[i].exp_cnt));
      end

      // Relock: row 11 was the first clean bit, 22 more complete the 23
      for (int i = 0; i < 21; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("relock_before", 32'(locked), 32'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("relock_after", 32'(locked), 32'd1);
      chk("relock_err_count", 32'(err_count), 32'd4);

      // Degenerate constant streams
      do_reset();
      ever_locked = 0;
      for (int i = 0; i < 500; i++) begin
         raw_step(1'b0);
         if (locked !== 1'b0 || locked2 !== 1'b0) ever_locked++;
      end
      for (int i = 0; i < 500; i++) begin
         raw_step(1'b1);
         if (locked !== 1'b0 || locked2 !== 1'b0) ever_locked++;
      end
      chk("degenerate_locked_cycles", 32'(ever_locked), 32'd0);
      chk("degenerate_err_count", 32'(err_count), 32'd0);

      // Enable gating mid-lock
      do_reset();
      lock_up("gate");
      for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      viol = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         if (locked !== 1'b1 || err_pulse !== 1'b0) viol++;
      end
      for (int i = 0; i < 100; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         if (locked !== 1'b1 || err_pulse !== 1'b0) viol++;
      end
      chk("gate_violations", 32'(viol), 32'd0);
      chk("gate_err_count", 32'(err_count), 32'd0);

      // Saturation on the 4-bit instance (20 errors, 32 allowed per window)
      do_reset();
      lock_up("sat");
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0);
         if (i == 19) begin
            chk("sat_pulse_when_saturated", 32'(err_pulse2), 32'd1);
            chk("sat_err_count2", 32'(err_count2), 32'd15);
         end
         step(1'b1, 1'b0, 1'b0, 1'b0);
      end
      chk("sat_locked2", 32'(locked2), 32'd1);
      chk("sat_dut1_clean", 32'(err_count), 32'd0);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      chk("sat_clear_vs_err_count", 32'(err_count2), 32'd0);
      chk("sat_clear_vs_err_pulse", 32'(err_pulse2), 32'd1);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("sat_count_after_clear", 32'(err_count2), 32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk("sat_clear_pulse", 32'(err_count2), 32'd0);
      chk("sat_clear_keeps_lock", 32'(locked2), 32'd1);

      // Asynchronous reset right after an error: pulse must vanish immediately
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("async_pre_pulse", 32'(err_pulse2), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("async_pulse", 32'(err_pulse2), 32'd0);
      chk("async_locked2", 32'(locked2), 32'd0);
      chk("async_count2", 32'(err_count2), 32'd0);
      chk("async_locked", 32'(locked), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
